// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared FSM state type and output buffer depth for the FIFO read streamer
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - 2-entry ordered output buffer; head entry drives the downstream stream
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  input  logic          rd_en,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [1:0]    cnt
);

  localparam int PW = $clog2(BUF_DEPTH);

  logic [DW-1:0] data_q [BUF_DEPTH];
  logic [DW-1:0] data_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] last_q, last_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]    cnt_q, cnt_d;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      data_d[wr_ptr_q] = wr_data;
      last_d[wr_ptr_q] = wr_last;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
      end
      last_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      last_q   <= last_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = data_q[rd_ptr_q];
  assign m_last  = m_valid & last_q[rd_ptr_q];
  assign cnt     = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - streams words out of a registered-read FIFO into a packetised valid/ready stream
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DW      = 8,
  parameter int PKT_LEN = 16
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          en,
  input  logic          rempty,
  input  logic [DW-1:0] rdata,
  output logic          rinc,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy
);

  localparam int BW = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  state_e        state_q, state_d;
  logic          inflight_q, inflight_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [1:0]    buf_cnt;
  logic          pop;
  logic [2:0]    credit;

  assign pop = m_valid & m_ready;

  // Words already committed to the buffer after this cycle's pop; a new read only
  // issues when its data is guaranteed a free slot on arrival.
  assign credit = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign rinc   = (state_q == ST_RUN) & ~rempty & (credit < 3'(BUF_DEPTH));
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en) begin
          state_d = ST_RUN;
        end else if (!inflight_q && (buf_cnt == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = rinc;
    beat_d     = beat_q;
    if (inflight_q) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
    end
  end

  stream_skid_buf #(
    .DW(DW)
  ) u_buf (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .wr_en   (inflight_q),
    .wr_data (rdata),
    .wr_last (beat_q == LAST_BEAT),
    .rd_en   (pop),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .cnt     (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized bench for fifo_rd_stream against a queue-based reference model
module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n, en, rempty, m_ready;
  logic [DW-1:0] rdata;
  logic          rinc, m_valid, m_last, busy;
  logic [DW-1:0] m_data;
  logic          rinc4, m_valid4, m_last4, busy4;
  logic [DW-1:0] m_data4;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DW(DW), .PKT_LEN(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy)
  );

  fifo_rd_stream #(.DW(DW), .PKT_LEN(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc4), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .m_last(m_last4), .busy(busy4)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int  acc_cnt, cyc, rinc_cnt, phase_acc, last_acc_cyc;
  bit  gap_mode, toggle_empty, gate, rnd_ready, hold_prev;
  int  ready_pct;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_rempty();
    rempty = (fifo_q.size() == 0) || (toggle_empty && gate);
  endtask

  task automatic cycle();
    logic          rinc_s;
    logic [DW-1:0] w;
    @(negedge rclk);
    cyc++;
    check("rinc_while_empty", 32'(rinc & rempty), 32'd0);
    check("rinc_pkt4_agree", 32'(rinc4), 32'(rinc));
    if (hold_prev) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(hold_data));
      check("hold_last", 32'(m_last), 32'(hold_last));
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("data", 32'(m_data), 32'(w));
        check("last16", 32'(m_last), 32'((acc_cnt % 16) == 15));
        check("data4", 32'(m_data4), 32'(w));
        check("last4", 32'(m_last4), 32'((acc_cnt % 4) == 3));
      end
      acc_cnt++;
      if (gap_mode && phase_acc > 0) check("gap", 32'(cyc - last_acc_cyc), 32'd1);
      phase_acc++;
      last_acc_cyc = cyc;
    end
    hold_prev = m_valid & ~m_ready;
    hold_data = m_data;
    hold_last = m_last;
    rinc_s    = rinc;
    if (rinc) rinc_cnt++;
    @(posedge rclk);
    #1;
    if (rinc_s) begin
      if (fifo_q.size() == 0) begin
        check("pop_of_empty_fifo", 32'd1, 32'd0);
      end else begin
        w     = fifo_q.pop_front();
        rdata = w;
        exp_q.push_back(w);
      end
    end
    if (rnd_ready) m_ready = ($urandom_range(0, 99) < ready_pct);
    gate = ~gate;
    drive_rempty();
  endtask

  task automatic do_reset();
    #2 rrst_n = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rinc", 32'(rinc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    acc_cnt   = 0;
    hold_prev = 1'b0;
    cycle();
    cycle();
    rrst_n = 1'b1;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (phase_acc < n && k < budget) begin
      cycle();
      k++;
    end
    check("accept_count", 32'(phase_acc), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      cycle();
      k++;
    end
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rrst_n = 1'b0; en = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = '0;
    toggle_empty = 1'b0; gate = 1'b0; rnd_ready = 1'b0; ready_pct = 70;
    gap_mode = 1'b0; hold_prev = 1'b0;
    acc_cnt = 0; cyc = 0; rinc_cnt = 0; phase_acc = 0; last_acc_cyc = 0;
    @(posedge rclk);
    #1;
    do_reset();

    // Full packet at full rate.
    for (int i = 1; i <= 16; i++) fifo_q.push_back(DW'(i));
    drive_rempty();
    en = 1'b1; m_ready = 1'b1; gap_mode = 1'b1; phase_acc = 0;
    wait_acc(16, 60);
    gap_mode = 1'b0;
    check("fifo_drained_1", 32'(fifo_q.size()), 32'd0);
    en = 1'b0;
    wait_idle(20);

    // Backpressure: only the buffer's two slots are fetched.
    for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
    drive_rempty();
    m_ready = 1'b0; en = 1'b1; rinc_cnt = 0;
    repeat (10) cycle();
    check("stall_rinc_pulses", 32'(rinc_cnt), 32'd2);
    check("stall_valid", 32'(m_valid), 32'd1);
    check("stall_head", 32'(m_data), 32'h01);
    m_ready = 1'b1; gap_mode = 1'b1; phase_acc = 0;
    wait_acc(4, 30);
    gap_mode = 1'b0;
    en = 1'b0;
    wait_idle(20);

    // Drop en with a full buffer: no more reads, buffered words drain.
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(8'h20 + i));
    drive_rempty();
    en = 1'b1; m_ready = 1'b1; phase_acc = 0;
    wait_acc(3, 30);
    m_ready = 1'b0;
    repeat (4) cycle();
    check("buffered_two", 32'(exp_q.size()), 32'd2);
    rinc_cnt = 0; en = 1'b0;
    cycle();
    m_ready = 1'b1; phase_acc = 0;
    wait_idle(20);
    check("drain_rinc", 32'(rinc_cnt), 32'd0);
    check("drain_words", 32'(phase_acc), 32'd2);
    check("fifo_left", 32'(fifo_q.size()), 32'd3);
    fifo_q.delete();
    drive_rempty();

    // rempty toggling every cycle.
    toggle_empty = 1'b1;
    for (int i = 0; i < 10; i++) fifo_q.push_back(DW'($urandom));
    drive_rempty();
    en = 1'b1; m_ready = 1'b1; phase_acc = 0;
    wait_acc(10, 80);
    check("fifo_drained_toggle", 32'(fifo_q.size()), 32'd0);
    toggle_empty = 1'b0;
    en = 1'b0;
    wait_idle(20);

    // Reset with a full buffer, then random backpressure across packet boundaries.
    for (int i = 0; i < 40; i++) fifo_q.push_back(DW'($urandom));
    drive_rempty();
    en = 1'b1; m_ready = 1'b0;
    repeat (5) cycle();
    check("pre_reset_full", 32'(exp_q.size()), 32'd2);
    check("pre_reset_valid", 32'(m_valid), 32'd1);
    do_reset();
    check("rinc_at_release", 32'(rinc), 32'd0);
    cycle();
    check("rinc_after_release", 32'(rinc), 32'd1);
    rnd_ready = 1'b1; phase_acc = 0;
    wait_acc(24, 300);
    rnd_ready = 1'b0; m_ready = 1'b1; en = 1'b0;
    wait_idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width in bits.
REQ-002 SHALL have parameter PKT_LEN, default 16, meaning words per packet (range 2..256).
REQ-003 SHALL have port rclk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rrst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, streaming enable.
REQ-006 SHALL have port rempty, input, 1, FIFO read-side empty flag.
REQ-007 SHALL have port rdata, input, DW, FIFO read data.
REQ-008 SHALL have port rinc, output, 1, FIFO read increment (pop request).
REQ-009 SHALL have port m_valid, input-side-free output, 1, downstream data valid.
REQ-010 SHALL have port m_ready, input, 1, downstream ready.
REQ-011 SHALL have port m_data, output, DW, downstream data.
REQ-012 SHALL have port m_last, output, 1, last word of packet.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL treat rdata as valid exactly one rclk after a cycle with rinc=1 (registered FIFO read).
REQ-015 SHALL hold an internal 2-entry output buffer; m_data/m_last/m_valid reflect its head entry.
REQ-016 SHALL count in-flight reads (0 or 1) and buffered words (0..2).
REQ-017 SHALL drive rinc = (state==RUN) & ~rempty & (buf_cnt + inflight - pop < 2), pop = m_valid & m_ready.
REQ-018 SHALL never assert rinc while rempty=1; SHALL never lose or duplicate a word.
REQ-019 SHALL sustain one word per cycle when rempty=0 and m_ready=1 continuously.
REQ-020 SHALL hold m_data/m_last stable while m_valid=1 and m_ready=0.
REQ-021 SHALL keep a beat counter (0..PKT_LEN-1), tagged at buffer write; m_last=1 on the word tagged PKT_LEN-1; counter wraps to 0 afterwards.
REQ-022 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->IDLE when inflight=0 and buf_cnt=0; DRAIN->RUN when en=1.
REQ-023 SHALL keep the beat counter across en toggles (packet boundaries not reset by en).
REQ-024 SHALL, on simultaneous buffer write and pop, keep buf_cnt unchanged and preserve order.

Reset
REQ-025 SHALL, on rrst_n=0, immediately set state=IDLE, rinc=0, m_valid=0, m_last=0, m_data=0, busy=0, buf_cnt=0, inflight=0, beat counter=0.
REQ-026 SHALL discard any in-flight or buffered word on reset asserted mid-operation.
REQ-027 SHALL release from reset synchronously to rclk, first possible rinc one cycle after deassertion with en=1.

Structure
REQ-028 SHALL place the FSM state enum and the buffer depth constant (2) in a shared package fifo_stream_pkg.
REQ-029 SHALL implement the 2-entry buffer as one sub-module stream_skid_buf; FSM, credit and beat logic in the top.

Verification
REQ-030 Reset then en=1, FIFO preloaded 0x01..0x10, m_ready=1 -> 16 words 0x01..0x10 on consecutive cycles, m_last only on 0x10.
REQ-031 FIFO holds 4 words, m_ready=0 -> rinc pulses exactly 2 times, m_valid=1 holding 0x01; m_ready=1 -> 0x01..0x04 in order, no gaps after release.
REQ-032 en dropped after 3 words accepted with 2 buffered -> no further rinc, both buffered words delivered, state IDLE, busy=0.
REQ-033 rempty toggling every cycle, m_ready=1 -> rinc never high while rempty=1; output sequence matches write order.
REQ-034 rrst_n pulsed low while buf_cnt=2 -> m_valid=0 same cycle; after release beat counter 0, next m_last after 16th word.
REQ-035 PKT_LEN=4, 12 words streamed with random m_ready -> m_last on words 4, 8, 12 only.
